// File: rtl/time_param_bank.sv
// Interval-duration bank: shadow registers committed atomically to an active set, plus a tick-driven countdown timer.
// Readback and all outputs are registered; a commit requested mid-countdown is deferred until the timer goes idle.
module time_param_bank #(
  parameter int                             NUM_INTERVALS = 4,
  parameter int                             WIDTH         = 4,
  parameter int                             SEL_W         = 2,
  parameter logic [NUM_INTERVALS*WIDTH-1:0] DEFAULT_TIMES = 16'h1236
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             prog_sync_i,
  input  logic [SEL_W-1:0] prog_sel_i,
  input  logic [WIDTH-1:0] time_val_in_i,
  input  logic             commit_i,
  input  logic             restore_defaults_i,
  input  logic [SEL_W-1:0] intervel_i,
  input  logic             start_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] time_val_out_o,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             expired_o,
  output logic             commit_pending_o,
  output logic             prog_err_o
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [SEL_W:0] NUM_SLOTS = (SEL_W+1)'(NUM_INTERVALS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             pending_q, pending_d;
  logic             prog_err_q, prog_err_d;
  logic [WIDTH-1:0] time_val_out_q;
  logic [WIDTH-1:0] shadow_q [NUM_INTERVALS];
  logic [WIDTH-1:0] shadow_d [NUM_INTERVALS];
  logic [WIDTH-1:0] active_q [NUM_INTERVALS];
  logic [WIDTH-1:0] active_d [NUM_INTERVALS];

  logic             busy;
  logic             wr_ok;
  logic             commit_now;
  logic [WIDTH-1:0] rd_val;

  assign busy       = (state_q == RUN);
  assign wr_ok      = ({1'b0, prog_sel_i} < NUM_SLOTS) && (time_val_in_i != '0);
  assign commit_now = !busy && (commit_i || pending_q);

  // Out-of-range selects fall through to slot 0.
  always_comb begin
    rd_val = active_q[0];
    for (int i = 0; i < NUM_INTERVALS; i++) begin
      if ({1'b0, intervel_i} == (SEL_W+1)'(i)) rd_val = active_q[i];
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    prog_err_d = 1'b0;
    if (restore_defaults_i) begin
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        shadow_d[i] = DEFAULT_TIMES[i*WIDTH +: WIDTH];
        active_d[i] = DEFAULT_TIMES[i*WIDTH +: WIDTH];
      end
      pending_d = 1'b0;
    end else begin
      // Active takes the pre-edge shadow, so a same-cycle write is not committed.
      if (commit_now) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end else if (commit_i) begin
        pending_d = 1'b1;
      end
      if (prog_sync_i) begin
        if (wr_ok) begin
          for (int i = 0; i < NUM_INTERVALS; i++) begin
            if ({1'b0, prog_sel_i} == (SEL_W+1)'(i)) shadow_d[i] = time_val_in_i;
          end
        end else begin
          prog_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d = rd_val;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick_i) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d   = '0;
            expired_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= IDLE;
      count_q        <= '0;
      expired_q      <= 1'b0;
      pending_q      <= 1'b0;
      prog_err_q     <= 1'b0;
      time_val_out_q <= DEFAULT_TIMES[WIDTH-1:0];
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        shadow_q[i] <= DEFAULT_TIMES[i*WIDTH +: WIDTH];
        active_q[i] <= DEFAULT_TIMES[i*WIDTH +: WIDTH];
      end
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      expired_q      <= expired_d;
      pending_q      <= pending_d;
      prog_err_q     <= prog_err_d;
      time_val_out_q <= rd_val;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
    end
  end

  assign time_val_out_o   = time_val_out_q;
  assign count_o          = count_q;
  assign busy_o           = busy;
  assign expired_o        = expired_q;
  assign commit_pending_o = pending_q;
  assign prog_err_o       = prog_err_q;

endmodule

// File: tb/tb_time_param_bank.sv
// Directed bench for time_param_bank with a rule-level reference model compared every cycle.
module tb_time_param_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       prog_sync, commit, restore, start, tick_in;
  logic [1:0] prog_sel, intervel;
  logic [3:0] time_val_in;
  logic [3:0] tvo, cnt;
  logic       busy, expired, pend, perr;

  logic       prog_sync_b;
  logic [1:0] prog_sel_b, intervel_b;
  logic [3:0] time_val_in_b;
  logic       zero_b;
  logic [3:0] tvo_b, cnt_b;
  logic       busy_b, expired_b, pend_b, perr_b;

  time_param_bank dut (
    .clk_i(clk), .reset_ni(rst_n),
    .prog_sync_i(prog_sync), .prog_sel_i(prog_sel), .time_val_in_i(time_val_in),
    .commit_i(commit), .restore_defaults_i(restore),
    .intervel_i(intervel), .start_i(start), .tick_i(tick_in),
    .time_val_out_o(tvo), .count_o(cnt), .busy_o(busy), .expired_o(expired),
    .commit_pending_o(pend), .prog_err_o(perr)
  );

  time_param_bank #(.NUM_INTERVALS(3), .WIDTH(4), .SEL_W(2), .DEFAULT_TIMES(12'h236)) dut_b (
    .clk_i(clk), .reset_ni(rst_n),
    .prog_sync_i(prog_sync_b), .prog_sel_i(prog_sel_b), .time_val_in_i(time_val_in_b),
    .commit_i(zero_b), .restore_defaults_i(zero_b),
    .intervel_i(intervel_b), .start_i(zero_b), .tick_i(zero_b),
    .time_val_out_o(tvo_b), .count_o(cnt_b), .busy_o(busy_b), .expired_o(expired_b),
    .commit_pending_o(pend_b), .prog_err_o(perr_b)
  );

  int checks = 0;
  int errors = 0;

  int defv [4];
  int m_sh [4];
  int m_ac [4];
  int m_cnt, m_busy, m_exp, m_pend, m_perr, m_tvo;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = defv[i];
      m_ac[i] = defv[i];
    end
    m_tvo = defv[0];
    m_cnt = 0; m_busy = 0; m_exp = 0; m_pend = 0; m_perr = 0;
  endtask

  // Next outputs from the behavioural rules, given the inputs applied this cycle.
  task model_step;
    int rd;
    int was_busy;
    rd = m_ac[int'(intervel)];
    was_busy = m_busy;
    m_tvo = rd;
    m_exp = 0;
    if (was_busy == 0) begin
      if (start) begin
        m_cnt  = rd;
        m_busy = 1;
      end
    end else if (tick_in) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 0;
        m_exp  = 1;
      end
    end
    m_perr = 0;
    if (restore) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = defv[i];
        m_ac[i] = defv[i];
      end
      m_pend = 0;
    end else begin
      if (was_busy == 0 && (commit || m_pend != 0)) begin
        m_ac   = m_sh;
        m_pend = 0;
      end else if (commit) begin
        m_pend = 1;
      end
      if (prog_sync) begin
        if (int'(prog_sel) < 4 && time_val_in != 4'd0) m_sh[int'(prog_sel)] = int'(time_val_in);
        else m_perr = 1;
      end
    end
  endtask

  task compare_all;
    chk("time_val_out", int'(tvo), m_tvo);
    chk("count", int'(cnt), m_cnt);
    chk("busy", int'(busy), m_busy);
    chk("expired", int'(expired), m_exp);
    chk("commit_pending", int'(pend), m_pend);
    chk("prog_err", int'(perr), m_perr);
  endtask

  task cyc;
    if (rst_n) model_step;
    @(posedge clk);
    @(negedge clk);
    compare_all;
  endtask

  initial begin
    defv[0] = 6; defv[1] = 3; defv[2] = 2; defv[3] = 1;
    rst_n = 1'b0;
    prog_sync = 0; prog_sel = 0; time_val_in = 0; commit = 0; restore = 0;
    intervel = 0; start = 0; tick_in = 0;
    prog_sync_b = 0; prog_sel_b = 0; time_val_in_b = 0; intervel_b = 0; zero_b = 0;
    model_reset;
    cyc; cyc;
    chk("rst_tvo", int'(tvo), 6);
    chk("rst_count", int'(cnt), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Readback sweep of defaults
    for (int i = 0; i < 4; i++) begin
      intervel = 2'(i);
      cyc;
      chk("sweep_default", int'(tvo), defv[i]);
    end

    // Shadow write is invisible until commit
    prog_sync = 1; prog_sel = 2; time_val_in = 5;
    cyc;
    prog_sync = 0; intervel = 2;
    cyc;
    chk("pre_commit_rd", int'(tvo), 2);
    commit = 1;
    cyc;
    commit = 0;
    cyc;
    chk("post_commit_rd", int'(tvo), 5);

    // Rejected write of zero
    prog_sync = 1; prog_sel = 1; time_val_in = 0;
    cyc;
    chk("err_zero_pulse", int'(perr), 1);
    prog_sync = 0; intervel = 1;
    cyc;
    chk("err_zero_clear", int'(perr), 0);
    cyc;
    chk("err_zero_slot_kept", int'(tvo), 3);

    // Out-of-range slot on a three-slot bank
    prog_sync_b = 1; prog_sel_b = 3; time_val_in_b = 7;
    cyc;
    chk("b_err_pulse", int'(perr_b), 1);
    prog_sync_b = 0; intervel_b = 3;
    cyc;
    chk("b_err_clear", int'(perr_b), 0);
    cyc;
    chk("b_oor_reads_slot0", int'(tvo_b), 6);
    intervel_b = 2;
    cyc;
    chk("b_slot2", int'(tvo_b), 2);

    // Countdown of 6 with ticks every third cycle, stray start mid-run
    intervel = 0; start = 1;
    cyc;
    start = 0;
    chk("cd_load", int'(cnt), 6);
    chk("cd_busy", int'(busy), 1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin start = 1; intervel = 1; end
      cyc;
      start = 0; intervel = 0;
      cyc;
      tick_in = 1;
      cyc;
      tick_in = 0;
      chk("cd_count", int'(cnt), 6 - k);
      if (k == 6) begin
        chk("cd_expired", int'(expired), 1);
        chk("cd_busy_fall", int'(busy), 0);
      end
    end
    cyc;
    chk("cd_expired_clear", int'(expired), 0);

    // Commit deferred across a countdown
    intervel = 0; start = 1;
    cyc;
    start = 0; prog_sync = 1; prog_sel = 0; time_val_in = 9;
    cyc;
    prog_sync = 0; commit = 1;
    cyc;
    commit = 0;
    chk("def_pending", int'(pend), 1);
    cyc;
    chk("def_rd_old", int'(tvo), 6);
    for (int k = 1; k <= 6; k++) begin
      tick_in = 1;
      cyc;
      tick_in = 0;
      if (k == 6) begin
        chk("def_expired", int'(expired), 1);
        chk("def_pending_hold", int'(pend), 1);
      end
      cyc;
    end
    chk("def_pending_clear", int'(pend), 0);
    cyc;
    chk("def_rd_new", int'(tvo), 9);

    // Restore beats a same-cycle write and commit
    prog_sync = 1; prog_sel = 1; time_val_in = 4; commit = 1; restore = 1;
    cyc;
    prog_sync = 0; commit = 0; restore = 0;
    chk("rst_def_no_err", int'(perr), 0);
    for (int i = 0; i < 4; i++) begin
      intervel = 2'(i);
      cyc;
      chk("restore_sweep", int'(tvo), defv[i]);
    end

    // Restore leaves a running count alone; reset aborts it asynchronously
    intervel = 0; start = 1;
    cyc;
    start = 0; tick_in = 1;
    cyc;
    tick_in = 0; restore = 1;
    cyc;
    restore = 0;
    chk("restore_keeps_count", int'(cnt), 5);
    chk("restore_keeps_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(cnt), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_expired", int'(expired), 0);
    model_reset;
    cyc;
    rst_n = 1'b1;
    cyc;
    cyc;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
